// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the match score keeper.
package score_pkg;

   typedef enum logic {
      PLAYING    = 1'b0,
      MATCH_OVER = 1'b1
   } match_state_t;

   // Same encoding as the game FSM's gameover output.
   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_WHITE = 2'b01;
   localparam logic [1:0] WIN_BLACK = 2'b10;

   typedef logic [3:0] bcd_digit_t;

   // Binary value of a two-digit BCD score (0..99).
   function automatic logic [6:0] bcd_to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
      return 7'(tens) * 7'd10 + 7'(ones);
   endfunction

endpackage

// File: rtl/score_keeper_bcd_counter2.sv
// Two-digit BCD counter that saturates at 99.
module bcd_counter2
   import score_pkg::*;
(
   input  logic       Clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       inc,
   output bcd_digit_t ones,
   output bcd_digit_t tens,
   output logic       at_max
);

   assign at_max = (tens == 4'd9) && (ones == 4'd9);

   // Digit update: clear has priority, increments at 99 are absorbed.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         ones <= 4'd0;
         tens <= 4'd0;
      end else if (clr) begin
         ones <= 4'd0;
         tens <= 4'd0;
      end else if (inc && !at_max) begin
         if (ones == 4'd9) begin
            ones <= 4'd0;
            tens <= tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Per-player BCD round scores with match-winner detection.
module score_keeper
   import score_pkg::*;
#(
   parameter int WIN_SCORE = 5,
   parameter int SAT_SCORE = 99
) (
   input  logic       Clk,
   input  logic       reset_n,
   input  logic       add,
   input  logic       whitewon,
   input  logic       blackwon,
   input  logic       clear_scores,
   output logic [3:0] white_ones,
   output logic [3:0] white_tens,
   output logic [3:0] black_ones,
   output logic [3:0] black_tens,
   output logic       score_evt,
   output logic       tie_err,
   output logic       match_over,
   output logic [1:0] match_winner
);

   // A winning score above the counter ceiling could never be reached.
   localparam int         WIN_EFF = (WIN_SCORE > SAT_SCORE) ? SAT_SCORE : WIN_SCORE;
   localparam logic [6:0] WIN_BIN = 7'(WIN_EFF);

   match_state_t state, state_next;
   logic add_q, first_cycle;
   logic add_edge, accept, inc_white, inc_black, tie;
   logic white_max, black_max, white_win, black_win;

   // The first cycle after reset only primes add_q, so an add already high
   // at release is not mistaken for a fresh strobe.
   assign add_edge  = add & ~add_q & ~first_cycle;
   assign accept    = add_edge & (state == PLAYING) & ~clear_scores;
   assign inc_white = accept & whitewon & ~blackwon;
   assign inc_black = accept & blackwon & ~whitewon;
   assign tie       = accept & (whitewon ~^ blackwon);

   assign white_win = inc_white & ~white_max &
                      ((bcd_to_bin(white_tens, white_ones) + 7'd1) == WIN_BIN);
   assign black_win = inc_black & ~black_max &
                      ((bcd_to_bin(black_tens, black_ones) + 7'd1) == WIN_BIN);

   // Strobe edge detector history and post-reset mask.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         add_q       <= 1'b0;
         first_cycle <= 1'b1;
      end else begin
         add_q       <= add;
         first_cycle <= 1'b0;
      end
   end

   // Match state register.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) state <= PLAYING;
      else          state <= state_next;
   end

   // Next match state: a winning increment ends the match, clear restarts it.
   always_comb begin
      state_next = state;
      case (state)
         PLAYING:    if (white_win || black_win) state_next = MATCH_OVER;
         MATCH_OVER: if (clear_scores)           state_next = PLAYING;
         default:    state_next = PLAYING;
      endcase
   end

   // Registered status outputs, updated on the same edge as the digits.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         score_evt    <= 1'b0;
         tie_err      <= 1'b0;
         match_over   <= 1'b0;
         match_winner <= WIN_NONE;
      end else begin
         score_evt  <= inc_white | inc_black;
         tie_err    <= tie;
         match_over <= (state_next == MATCH_OVER);
         if (clear_scores)   match_winner <= WIN_NONE;
         else if (white_win) match_winner <= WIN_WHITE;
         else if (black_win) match_winner <= WIN_BLACK;
      end
   end

   bcd_counter2 u_white (
      .Clk     (Clk),
      .reset_n (reset_n),
      .clr     (clear_scores),
      .inc     (inc_white),
      .ones    (white_ones),
      .tens    (white_tens),
      .at_max  (white_max)
   );

   bcd_counter2 u_black (
      .Clk     (Clk),
      .reset_n (reset_n),
      .clr     (clear_scores),
      .inc     (inc_black),
      .ones    (black_ones),
      .tens    (black_tens),
      .at_max  (black_max)
   );

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: vector table, directed corner sequences and
// randomized traffic against an integer-score reference model.
module tb_score_keeper;

   logic Clk = 1'b0;
   logic reset_n, add, whitewon, blackwon, clear_scores;

   logic [3:0] a_wo, a_wt, a_bo, a_bt;
   logic       a_evt, a_tie, a_over;
   logic [1:0] a_win;
   logic [3:0] b_wo, b_wt, b_bo, b_bt;
   logic       b_evt, b_tie, b_over;
   logic [1:0] b_win;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   always #5 Clk = ~Clk;

   score_keeper #(.WIN_SCORE(5)) u5 (
      .Clk(Clk), .reset_n(reset_n), .add(add), .whitewon(whitewon),
      .blackwon(blackwon), .clear_scores(clear_scores),
      .white_ones(a_wo), .white_tens(a_wt), .black_ones(a_bo), .black_tens(a_bt),
      .score_evt(a_evt), .tie_err(a_tie), .match_over(a_over), .match_winner(a_win)
   );

   score_keeper #(.WIN_SCORE(99)) u99 (
      .Clk(Clk), .reset_n(reset_n), .add(add), .whitewon(whitewon),
      .blackwon(blackwon), .clear_scores(clear_scores),
      .white_ones(b_wo), .white_tens(b_wt), .black_ones(b_bo), .black_tens(b_bt),
      .score_evt(b_evt), .tie_err(b_tie), .match_over(b_over), .match_winner(b_win)
   );

   // ---------------- reference model (integer scores) ----------------
   int         win_of [2] = '{5, 99};
   int         mw [2], mb [2];
   bit         mover [2], mevt [2], mtie [2];
   logic [1:0] mwin [2];
   bit         m_prev, m_first;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mw[i] = 0; mb[i] = 0; mover[i] = 0; mevt[i] = 0; mtie[i] = 0; mwin[i] = 2'b00;
      end
      m_prev = 0; m_first = 1;
   endtask

   task automatic model_edge();
      bit ev;
      if (!reset_n) begin
         model_reset();
         return;
      end
      ev = add && !m_prev && !m_first;
      m_prev = add; m_first = 0;
      for (int i = 0; i < 2; i++) begin
         mevt[i] = 0; mtie[i] = 0;
         if (clear_scores) begin
            mw[i] = 0; mb[i] = 0; mover[i] = 0; mwin[i] = 2'b00;
         end else if (ev && !mover[i]) begin
            if (whitewon && !blackwon) begin
               mevt[i] = 1;
               if (mw[i] < 99) begin
                  mw[i]++;
                  if (mw[i] == win_of[i]) begin mover[i] = 1; mwin[i] = 2'b01; end
               end
            end else if (blackwon && !whitewon) begin
               mevt[i] = 1;
               if (mb[i] < 99) begin
                  mb[i]++;
                  if (mb[i] == win_of[i]) begin mover[i] = 1; mwin[i] = 2'b10; end
               end
            end else begin
               mtie[i] = 1;
            end
         end
      end
   endtask

   function automatic logic [20:0] pack(int w, int b, bit evt, bit tie, bit over, logic [1:0] win);
      return {4'(w / 10), 4'(w % 10), 4'(b / 10), 4'(b % 10), evt, tie, over, win};
   endfunction

   function automatic logic [20:0] exp_of(int i);
      return pack(mw[i], mb[i], mevt[i], mtie[i], mover[i], mwin[i]);
   endfunction

   function automatic logic [20:0] act_a();
      return {a_wt, a_wo, a_bt, a_bo, a_evt, a_tie, a_over, a_win};
   endfunction

   function automatic logic [20:0] act_b();
      return {b_wt, b_wo, b_bt, b_bo, b_evt, b_tie, b_over, b_win};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic check_all();
      chk($sformatf("u5 model cyc%0d", cyc), 32'(act_a()), 32'(exp_of(0)));
      chk($sformatf("u99 model cyc%0d", cyc), 32'(act_b()), 32'(exp_of(1)));
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later.
   task automatic step();
      @(posedge Clk);
      model_edge();
      #1;
      cyc++;
      check_all();
   endtask

   task automatic drive(input bit a, input bit w, input bit b, input bit c);
      add = a; whitewon = w; blackwon = b; clear_scores = c;
   endtask

   task automatic pulse(input bit w, input bit b);
      drive(1, w, b, 0); step();
      drive(0, w, b, 0); step();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         a, w, b, c;
      logic [20:0] exp;
   } vec_t;

   vec_t vt [$];

   function automatic vec_t mkv(bit a, bit w, bit b, bit c, int sw, int sb,
                                bit evt, bit tie, bit over, logic [1:0] win);
      vec_t v;
      v.a = a; v.w = w; v.b = b; v.c = c;
      v.exp = pack(sw, sb, evt, tie, over, win);
      return v;
   endfunction

   int evt_cnt;

   initial begin
      // W,B,W,B,W,B,W,W then a stray black add and a clear, WIN_SCORE = 5
      vt.push_back(mkv(1,1,0,0, 1,0, 1,0,0,2'b00));
      vt.push_back(mkv(0,0,0,0, 1,0, 0,0,0,2'b00));
      vt.push_back(mkv(1,0,1,0, 1,1, 1,0,0,2'b00));
      vt.push_back(mkv(0,0,0,0, 1,1, 0,0,0,2'b00));
      vt.push_back(mkv(1,1,0,0, 2,1, 1,0,0,2'b00));
      vt.push_back(mkv(0,0,0,0, 2,1, 0,0,0,2'b00));
      vt.push_back(mkv(1,0,1,0, 2,2, 1,0,0,2'b00));
      vt.push_back(mkv(0,0,0,0, 2,2, 0,0,0,2'b00));
      vt.push_back(mkv(1,1,0,0, 3,2, 1,0,0,2'b00));
      vt.push_back(mkv(0,0,0,0, 3,2, 0,0,0,2'b00));
      vt.push_back(mkv(1,0,1,0, 3,3, 1,0,0,2'b00));
      vt.push_back(mkv(0,0,0,0, 3,3, 0,0,0,2'b00));
      vt.push_back(mkv(1,1,0,0, 4,3, 1,0,0,2'b00));
      vt.push_back(mkv(0,0,0,0, 4,3, 0,0,0,2'b00));
      vt.push_back(mkv(1,1,0,0, 5,3, 1,0,1,2'b01));
      vt.push_back(mkv(0,0,0,0, 5,3, 0,0,1,2'b01));
      vt.push_back(mkv(1,0,1,0, 5,3, 0,0,1,2'b01));
      vt.push_back(mkv(0,0,0,0, 5,3, 0,0,1,2'b01));
      vt.push_back(mkv(0,0,0,1, 0,0, 0,0,0,2'b00));
      vt.push_back(mkv(0,0,0,0, 0,0, 0,0,0,2'b00));

      // Reset state
      reset_n = 0; drive(0, 0, 0, 0);
      model_reset();
      #1 check_all();
      step(); step();
      reset_n = 1;
      drive(0, 0, 0, 0); step();

      // Table-driven run on the WIN_SCORE=5 instance
      foreach (vt[k]) begin
         drive(vt[k].a, vt[k].w, vt[k].b, vt[k].c);
         step();
         chk($sformatf("table row%0d", k), 32'(act_a()), 32'(vt[k].exp));
      end

      // Three white pulses from zero
      drive(0, 0, 0, 1); step();
      evt_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 0, 0); step(); evt_cnt += int'(a_evt);
         drive(0, 1, 0, 0); step(); evt_cnt += int'(a_evt);
      end
      chk("three white score", {24'd0, a_wt, a_wo}, 32'h03);
      chk("three white black zero", {24'd0, a_bt, a_bo}, 32'h00);
      chk("three white evt count", 32'(evt_cnt), 32'd3);

      // Held add counts once
      drive(0, 0, 0, 1); step();
      evt_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, 1, 0); step(); evt_cnt += int'(a_evt);
      end
      drive(0, 0, 0, 0); step();
      chk("held add black", {24'd0, a_bt, a_bo}, 32'h01);
      chk("held add evt count", 32'(evt_cnt), 32'd1);

      // 100 white events on WIN_SCORE=99
      drive(0, 0, 0, 1); step();
      for (int k = 1; k <= 100; k++) begin
         drive(1, 1, 0, 0); step();
         if (k == 10)  chk("u99 tenth", {24'd0, b_wt, b_wo}, 32'h10);
         if (k == 99)  chk("u99 win", {24'd0, b_wt, b_wo, b_over, b_win}, {21'd0, 8'h99, 1'b1, 2'b01});
         if (k == 100) chk("u99 ignored", {24'd0, b_wt, b_wo, 3'd0, b_evt}, {21'd0, 8'h99, 3'd0, 1'b0});
         drive(0, 1, 0, 0); step();
      end

      // Tie errors, then clear coincident with a white edge
      drive(0, 0, 0, 1); step();
      drive(1, 1, 1, 0); step();
      chk("tie both", {31'd0, a_tie}, 32'd1);
      drive(0, 0, 0, 0); step();
      drive(1, 0, 0, 0); step();
      chk("tie neither", {31'd0, a_tie}, 32'd1);
      drive(0, 0, 0, 0); step();
      chk("tie scores", {16'd0, a_wt, a_wo, a_bt, a_bo}, 32'd0);
      drive(0, 1, 0, 0); step();
      drive(1, 1, 0, 1); step();
      chk("clear vs edge", {23'd0, a_wt, a_wo, a_evt}, 32'd0);
      drive(1, 1, 0, 0); step();
      chk("clear held no refire", {23'd0, a_wt, a_wo, a_evt}, 32'd0);

      // Asynchronous reset mid-cycle at 3-2 with add high
      drive(0, 0, 0, 1); step();
      pulse(1, 0); pulse(0, 1); pulse(1, 0); pulse(0, 1);
      drive(1, 1, 0, 0); step();
      chk("pre reset score", {16'd0, a_wt, a_wo, a_bt, a_bo}, 32'h0302);
      #2 reset_n = 0;
      model_reset();
      #1 check_all();
      chk("async reset zero", 32'(act_a()), 32'd0);
      step(); step();
      reset_n = 1;
      step(); step(); step();
      chk("held add after reset", {24'd0, a_wt, a_wo, 3'd0, a_evt}, 32'd0);
      drive(0, 1, 0, 0); step();
      drive(1, 1, 0, 0); step();
      chk("fresh edge after reset", {24'd0, a_wt, a_wo, 3'd0, a_evt}, 32'h11);

      // Randomized traffic against the model
      drive(0, 0, 0, 1); step();
      for (int k = 0; k < 3000; k++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
